// File: rtl/dump_ctrl_pkg.sv
// Shared types and constants for the waveform-dump window sequencer.
package dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_DL    = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_DUMPING    = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam int unsigned DEFAULT_CW  = 32;
  localparam int unsigned FRAME_NEVER = 0;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a delay flop for rise/fall detection.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d1, d2, d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= RST_VAL;
      d2 <= RST_VAL;
      d3 <= RST_VAL;
    end else begin
      d1 <= d;
      d2 <= d1;
      d3 <= d2;
    end
  end

  assign rise = d2 & ~d3;
  assign fall = d3 & ~d2;

endmodule

// File: rtl/dump_window_ctrl.sv
// Frame-counting sequencer that opens/closes the waveform dump window
// and raises a sticky finish request at programmed frame numbers.
module dump_window_ctrl
  import dump_ctrl_pkg::*;
#(
  parameter int unsigned CW       = DEFAULT_CW,
  parameter int unsigned USE_DL   = 0,
  parameter int unsigned DL_GUARD = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_en,
  input  logic          vs,
  input  logic          downloading,
  input  logic [CW-1:0] start_frame,
  input  logic [CW-1:0] stop_frame,
  input  logic [CW-1:0] finish_frame,
  output logic [CW-1:0] frame_cnt,
  output logic          frame_stb,
  output logic          dump_on,
  output logic          dump_off,
  output logic          dumping,
  output logic          sim_done,
  output logic [2:0]    state
);

  localparam int unsigned GW = (DL_GUARD > 0) ? $clog2(DL_GUARD + 1) : 1;
  localparam logic [CW-1:0] NEVER = CW'(FRAME_NEVER);

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_nxt, nxt;
  logic          stb_nxt, on_nxt, off_nxt, done_nxt;
  logic          vs_fall, dl_rise, dl_fall;
  logic [GW-1:0] guard_cnt;
  logic          guard_ok, empty_win;

  // vs idles high, so its synchronizer resets high to avoid a false fall
  sync_edge #(.RST_VAL(1'b1)) u_vs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vs),
    .rise  (),
    .fall  (vs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_dl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (downloading),
    .rise  (dl_rise),
    .fall  (dl_fall)
  );

  assign guard_ok = (guard_cnt == GW'(DL_GUARD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      guard_cnt <= '0;
    else if (!guard_ok)
      guard_cnt <= guard_cnt + GW'(1);
  end

  assign nxt       = (frame_cnt == '1) ? frame_cnt : frame_cnt + CW'(1);
  assign empty_win = (stop_frame != NEVER) && (stop_frame <= start_frame);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = frame_cnt;
    stb_nxt   = 1'b0;
    on_nxt    = 1'b0;
    off_nxt   = 1'b0;
    done_nxt  = sim_done;

    if ((state_q == ST_WAIT_START || state_q == ST_DUMPING) && vs_fall) begin
      cnt_nxt = nxt;
      stb_nxt = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (dump_en) begin
          if (USE_DL != 0) begin
            state_nxt = ST_WAIT_DL;
          end else begin
            state_nxt = ST_WAIT_START;
            cnt_nxt   = '0;
          end
        end
      end
      ST_WAIT_DL: begin
        if (dl_fall && guard_ok) begin
          cnt_nxt   = '0;
          state_nxt = ST_WAIT_START;
        end
      end
      ST_WAIT_START, ST_DUMPING: begin
        // finish outranks download restart, which outranks stop/start
        if (vs_fall && finish_frame != NEVER && nxt == finish_frame) begin
          done_nxt  = 1'b1;
          off_nxt   = (state_q == ST_DUMPING);
          state_nxt = ST_DONE;
        end else if (USE_DL != 0 && dl_rise && guard_ok) begin
          off_nxt   = (state_q == ST_DUMPING);
          state_nxt = ST_WAIT_DL;
        end else if (state_q == ST_WAIT_START) begin
          // start_frame == 0 opens only from a fresh count so a closed window stays closed
          if (!empty_win &&
              ((start_frame == NEVER && frame_cnt == '0) ||
               (vs_fall && start_frame != NEVER && nxt == start_frame))) begin
            on_nxt    = 1'b1;
            state_nxt = ST_DUMPING;
          end
        end else if (vs_fall && stop_frame != NEVER && nxt == stop_frame) begin
          off_nxt   = 1'b1;
          state_nxt = ST_WAIT_START;
        end
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      frame_cnt <= '0;
      frame_stb <= 1'b0;
      dump_on   <= 1'b0;
      dump_off  <= 1'b0;
      sim_done  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      frame_cnt <= cnt_nxt;
      frame_stb <= stb_nxt;
      dump_on   <= on_nxt;
      dump_off  <= off_nxt;
      sim_done  <= done_nxt;
    end
  end

  assign dumping = (state_q == ST_DUMPING);
  assign state   = state_q;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Directed bench for dump_window_ctrl: one instance without download gating,
// one with download gating and a short guard.
module tb_dump_window_ctrl;

  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          dump_en0 = 1'b0, vs0 = 1'b1, dl0 = 1'b0;
  logic [CW-1:0] start0 = '0, stop0 = '0, finish0 = '0;
  logic [CW-1:0] fc0;
  logic          stb0, on0, off0, dumping0, done0;
  logic [2:0]    st0;

  logic          dump_en1 = 1'b0, vs1 = 1'b1, dl1 = 1'b0;
  logic [CW-1:0] start1 = '0, stop1 = '0, finish1 = '0;
  logic [CW-1:0] fc1;
  logic          stb1, on1, off1, dumping1, done1;
  logic [2:0]    st1;

  int cmp = 0;
  int err = 0;
  int on0_n = 0, off0_n = 0, on1_n = 0, off1_n = 0, viol = 0;
  logic [CW-1:0] on0_fc = '0, off0_fc = '0;

  always #5 clk = ~clk;

  dump_window_ctrl #(.CW(CW), .USE_DL(0), .DL_GUARD(1000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dump_en(dump_en0), .vs(vs0), .downloading(dl0),
    .start_frame(start0), .stop_frame(stop0), .finish_frame(finish0),
    .frame_cnt(fc0), .frame_stb(stb0), .dump_on(on0), .dump_off(off0),
    .dumping(dumping0), .sim_done(done0), .state(st0)
  );

  dump_window_ctrl #(.CW(CW), .USE_DL(1), .DL_GUARD(100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dump_en(dump_en1), .vs(vs1), .downloading(dl1),
    .start_frame(start1), .stop_frame(stop1), .finish_frame(finish1),
    .frame_cnt(fc1), .frame_stb(stb1), .dump_on(on1), .dump_off(off1),
    .dumping(dumping1), .sim_done(done1), .state(st1)
  );

  always @(negedge clk) begin
    if (on0) begin on0_n++; on0_fc = fc0; end
    if (off0) begin off0_n++; off0_fc = fc0; end
    if (on1) on1_n++;
    if (off1) off1_n++;
    if ((on0 && off0) || (on1 && off1)) viol++;
    if (rst_n && ((dumping0 !== (st0 == 3'd3)) || (dumping1 !== (st1 == 3'd3)))) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic vs_pulse(input int which);
    if (which == 0) vs0 = 1'b0; else vs1 = 1'b0;
    repeat (6) tick();
    if (which == 0) vs0 = 1'b1; else vs1 = 1'b1;
    repeat (6) tick();
  endtask

  task automatic clear_mon();
    on0_n = 0; off0_n = 0; on1_n = 0; off1_n = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    cmp++;
    if ({fc0, stb0, on0, off0, dumping0, done0, st0} !== '0) begin
      err++; $display("FAIL reset_dut0 got fc=%0d st=%0d done=%0b want all 0", fc0, st0, done0);
    end
    cmp++;
    if ({fc1, stb1, on1, off1, dumping1, done1, st1} !== '0) begin
      err++; $display("FAIL reset_dut1 got fc=%0d st=%0d done=%0b want all 0", fc1, st1, done1);
    end
  endtask

  task automatic test_window();
    dump_en0 = 1'b1; start0 = 3; stop0 = 6; finish0 = 0;
    do_reset();
    clear_mon();
    cmp++;
    if (st0 !== 3'd2) begin err++; $display("FAIL win_enter got st=%0d want 2", st0); end
    for (int i = 1; i <= 10; i++) begin
      vs_pulse(0);
      cmp++;
      if (fc0 !== CW'(i)) begin err++; $display("FAIL win_fc got %0d want %0d", fc0, i); end
      cmp++;
      if (dumping0 !== (i >= 3 && i <= 5)) begin
        err++; $display("FAIL win_dumping frame %0d got %0b want %0b", i, dumping0, (i >= 3 && i <= 5));
      end
    end
    cmp++;
    if (on0_n !== 1 || on0_fc !== 3) begin
      err++; $display("FAIL win_on got n=%0d fc=%0d want n=1 fc=3", on0_n, on0_fc);
    end
    cmp++;
    if (off0_n !== 1 || off0_fc !== 6) begin
      err++; $display("FAIL win_off got n=%0d fc=%0d want n=1 fc=6", off0_n, off0_fc);
    end
    cmp++;
    if (st0 !== 3'd2) begin err++; $display("FAIL win_final_state got %0d want 2", st0); end
  endtask

  task automatic test_dl_guard();
    dl1 = 1'b1; dump_en1 = 1'b1; start1 = 10; stop1 = 0; finish1 = 0;
    do_reset();
    repeat (45) tick();
    dl1 = 1'b0;
    repeat (20) tick();
    cmp++;
    if (st1 !== 3'd1) begin err++; $display("FAIL dl_guard_ignored got st=%0d want 1", st1); end
    vs_pulse(1);
    cmp++;
    if (fc1 !== 0 || st1 !== 3'd1) begin
      err++; $display("FAIL dl_wait_nocount got fc=%0d st=%0d want fc=0 st=1", fc1, st1);
    end
    repeat (120) tick();
    dl1 = 1'b1;
    repeat (300) tick();
    dl1 = 1'b0;
    repeat (6) tick();
    cmp++;
    if (st1 !== 3'd2 || fc1 !== 0) begin
      err++; $display("FAIL dl_second_fall got st=%0d fc=%0d want st=2 fc=0", st1, fc1);
    end
    vs_pulse(1);
    vs_pulse(1);
    cmp++;
    if (fc1 !== 2) begin err++; $display("FAIL dl_count got %0d want 2", fc1); end
  endtask

  task automatic test_finish();
    dump_en0 = 1'b0; start0 = 0; stop0 = 0; finish0 = 4;
    do_reset();
    clear_mon();
    dump_en0 = 1'b1;
    tick();
    cmp++;
    if (st0 !== 3'd2) begin err++; $display("FAIL fin_enter got st=%0d want 2", st0); end
    tick();
    cmp++;
    if (on0 !== 1'b1 || st0 !== 3'd3) begin
      err++; $display("FAIL fin_imm_on got on=%0b st=%0d want on=1 st=3", on0, st0);
    end
    for (int i = 1; i <= 4; i++) vs_pulse(0);
    cmp++;
    if (done0 !== 1'b1 || st0 !== 3'd4 || dumping0 !== 1'b0) begin
      err++; $display("FAIL fin_done got done=%0b st=%0d dumping=%0b want 1 4 0", done0, st0, dumping0);
    end
    cmp++;
    if (off0_n !== 1 || off0_fc !== 4) begin
      err++; $display("FAIL fin_off got n=%0d fc=%0d want n=1 fc=4", off0_n, off0_fc);
    end
    vs_pulse(0);
    vs_pulse(0);
    cmp++;
    if (fc0 !== 4 || st0 !== 3'd4 || done0 !== 1'b1) begin
      err++; $display("FAIL fin_hold got fc=%0d st=%0d done=%0b want 4 4 1", fc0, st0, done0);
    end
  endtask

  task automatic test_empty();
    dump_en0 = 1'b1; start0 = 5; stop0 = 5; finish0 = 0;
    do_reset();
    clear_mon();
    for (int i = 1; i <= 7; i++) vs_pulse(0);
    cmp++;
    if (on0_n !== 0 || st0 !== 3'd2) begin
      err++; $display("FAIL empty_no_on got n=%0d st=%0d want n=0 st=2", on0_n, st0);
    end
    cmp++;
    if (fc0 !== 7) begin err++; $display("FAIL empty_count got %0d want 7", fc0); end
  endtask

  task automatic test_dl_restart();
    dl1 = 1'b0; dump_en1 = 1'b1; start1 = 2; stop1 = 0; finish1 = 0;
    do_reset();
    repeat (110) tick();
    dl1 = 1'b1;
    repeat (6) tick();
    dl1 = 1'b0;
    repeat (6) tick();
    clear_mon();
    cmp++;
    if (st1 !== 3'd2 || fc1 !== 0) begin
      err++; $display("FAIL rst_dl_enter got st=%0d fc=%0d want 2 0", st1, fc1);
    end
    for (int i = 1; i <= 4; i++) vs_pulse(1);
    cmp++;
    if (fc1 !== 4 || st1 !== 3'd3) begin
      err++; $display("FAIL rst_dl_dumping got fc=%0d st=%0d want 4 3", fc1, st1);
    end
    dl1 = 1'b1;
    repeat (6) tick();
    cmp++;
    if (off1_n !== 1 || st1 !== 3'd1 || fc1 !== 4 || dumping1 !== 1'b0) begin
      err++; $display("FAIL rst_dl_rise got off=%0d st=%0d fc=%0d dumping=%0b want 1 1 4 0",
                      off1_n, st1, fc1, dumping1);
    end
    dl1 = 1'b0;
    repeat (6) tick();
    cmp++;
    if (fc1 !== 0 || st1 !== 3'd2 || on1_n !== 1) begin
      err++; $display("FAIL rst_dl_fall got fc=%0d st=%0d on=%0d want 0 2 1", fc1, st1, on1_n);
    end
  endtask

  task automatic test_async_reset();
    dump_en0 = 1'b1; start0 = 1; stop0 = 0; finish0 = 0;
    do_reset();
    vs_pulse(0);
    cmp++;
    if (st0 !== 3'd3) begin err++; $display("FAIL ar_setup got st=%0d want 3", st0); end
    clear_mon();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    dump_en0 = 1'b0;
    #1;
    cmp++;
    if ({fc0, stb0, on0, off0, dumping0, done0, st0} !== '0) begin
      err++; $display("FAIL ar_immediate got fc=%0d st=%0d dumping=%0b want all 0", fc0, st0, dumping0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    cmp++;
    if (st0 !== 3'd0 || off0_n !== 0 || fc0 !== 0) begin
      err++; $display("FAIL ar_release got st=%0d off=%0d fc=%0d want 0 0 0", st0, off0_n, fc0);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_dl_guard();
    test_finish();
    test_empty();
    test_dl_restart();
    test_async_reset();
    cmp++;
    if (viol !== 0) begin err++; $display("FAIL invariants got %0d violations want 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
